hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit.sv | 85 ++++++++
 tb/tb_hazard_forward_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: shadow EX/MEM/WB tracking for forwarding, load-use stall, branch flush and event counters
module hazard_forward_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        use_rs1_d,
  input  logic        use_rs2_d,
  input  logic [4:0]  rd_d,
  input  logic        regwrite_d,
  input  logic        memread_d,
  input  logic        pcsrc_e,
  output logic [1:0]  forward_a_e,
  output logic [1:0]  forward_b_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  logic [4:0]  ex_rs1_q, ex_rs2_q, ex_rd_q, mem_rd_q, wb_rd_q;
  logic        ex_regwrite_q, ex_memread_q, mem_regwrite_q, wb_regwrite_q;
  logic [4:0]  ex_rs1_d, ex_rs2_d, ex_rd_d, mem_rd_d, wb_rd_d;
  logic        ex_regwrite_d, ex_memread_d, mem_regwrite_d, wb_regwrite_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic        mem_ok, wb_ok, lwstall;
  // Unused sources are captured as x0 so they can never match a producer.
  always_comb begin
    mem_ok = mem_regwrite_q && (mem_rd_q != 5'd0);
    wb_ok  = wb_regwrite_q && (wb_rd_q != 5'd0);
    forward_a_e = (mem_ok && mem_rd_q == ex_rs1_q) ? 2'b10 :
                  (wb_ok && wb_rd_q == ex_rs1_q)   ? 2'b01 : 2'b00;
    forward_b_e = (mem_ok && mem_rd_q == ex_rs2_q) ? 2'b10 :
                  (wb_ok && wb_rd_q == ex_rs2_q)   ? 2'b01 : 2'b00;
    lwstall = ex_memread_q && (ex_rd_q != 5'd0) &&
              ((use_rs1_d && rs1_d == ex_rd_q) || (use_rs2_d && rs2_d == ex_rd_q));
    stall_f = lwstall && !pcsrc_e;
    stall_d = lwstall && !pcsrc_e;
    flush_d = pcsrc_e;
    flush_e = lwstall || pcsrc_e;
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end
  always_comb begin
    ex_rs1_d       = (flush_e || !use_rs1_d) ? 5'd0 : rs1_d;
    ex_rs2_d       = (flush_e || !use_rs2_d) ? 5'd0 : rs2_d;
    ex_rd_d        = flush_e ? 5'd0 : rd_d;
    ex_regwrite_d  = flush_e ? 1'b0 : regwrite_d;
    ex_memread_d   = flush_e ? 1'b0 : memread_d;
    mem_rd_d       = ex_rd_q;
    mem_regwrite_d = ex_regwrite_q;
    wb_rd_d        = mem_rd_q;
    wb_regwrite_d  = mem_regwrite_q;
    stall_cnt_d    = (stall_d && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d    = (flush_d && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs1_q       <= 5'd0;
      ex_rs2_q       <= 5'd0;
      ex_rd_q        <= 5'd0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_rd_q       <= 5'd0;
      mem_regwrite_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_regwrite_q  <= 1'b0;
      stall_cnt_q    <= 16'd0;
      flush_cnt_q    <= 16'd0;
    end else begin
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_rd_q        <= wb_rd_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed vector table, corner sequences and randomized reference-model check
module tb_hazard_forward_unit;
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;
  typedef struct {
    instr_t      i;
    logic        pc;
    logic [39:0] exp;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [4:0]  rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic        use_rs1_d = 1'b0, use_rs2_d = 1'b0, regwrite_d = 1'b0, memread_d = 1'b0, pcsrc_e = 1'b0;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [15:0] stall_cnt, flush_cnt;
  int          checks = 0, failures = 0;

  hazard_forward_unit dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rd_d(rd_d), .regwrite_d(regwrite_d), .memread_d(memread_d), .pcsrc_e(pcsrc_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(int rs1, int rs2, bit u1, bit u2, int rd, bit rw, bit mr);
    instr_t x;
    x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.u1 = u1; x.u2 = u2; x.rd = 5'(rd); x.rw = rw; x.mr = mr;
    return x;
  endfunction

  function automatic logic [39:0] ex(int fa, int fb, bit sf, bit sd, bit fd, bit fe, int sc, int fc);
    return {2'(fa), 2'(fb), sf, sd, fd, fe, 16'(sc), 16'(fc)};
  endfunction

  function automatic logic [39:0] obs();
    return {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e, stall_cnt, flush_cnt};
  endfunction

  task automatic drive(input instr_t x, input logic pc);
    rs1_d = x.rs1; rs2_d = x.rs2; use_rs1_d = x.u1; use_rs2_d = x.u2;
    rd_d = x.rd; regwrite_d = x.rw; memread_d = x.mr; pcsrc_e = pc;
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b sc=%h fc=%h, want fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b sc=%h fc=%h",
               name, act[39:38], act[37:36], act[35], act[34], act[33], act[32], act[31:16], act[15:0],
               req[39:38], req[37:36], req[35], req[34], req[33], req[32], req[31:16], req[15:0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference model: the last three accepted instructions, youngest first (EX, MEM, WB).
  instr_t pipe[3];
  int     m_sc, m_fc;

  function automatic logic [4:0] src(instr_t x, bit second);
    return second ? (x.u2 ? x.rs2 : 5'd0) : (x.u1 ? x.rs1 : 5'd0);
  endfunction

  function automatic int fwd(logic [4:0] r);
    if (r == 0) return 0;
    if (pipe[1].rw && pipe[1].rd == r) return 2;
    if (pipe[2].rw && pipe[2].rd == r) return 1;
    return 0;
  endfunction

  function automatic logic [39:0] model_out(instr_t dec, logic pc);
    bit lw;
    lw = pipe[0].mr && pipe[0].rd != 0 &&
         ((dec.u1 && dec.rs1 == pipe[0].rd) || (dec.u2 && dec.rs2 == pipe[0].rd));
    return ex(fwd(src(pipe[0], 0)), fwd(src(pipe[0], 1)), lw && !pc, lw && !pc, pc, lw || pc, m_sc, m_fc);
  endfunction

  task automatic model_step(instr_t dec, logic pc, logic r);
    logic [39:0] o;
    o = model_out(dec, pc);
    if (r) begin
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0; m_sc = 0; m_fc = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = o[32] ? '0 : dec;
      if (o[34]) m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
      if (o[33]) m_fc = (m_fc < 65535) ? m_fc + 1 : 65535;
    end
  endtask

  vec_t vt[22];
  instr_t nop, rdr7, cons5;

  initial begin
    nop   = '0;
    rdr7  = mk(7, 7, 1, 1, 8, 1, 0);
    cons5 = mk(1, 5, 1, 1, 11, 1, 0);
    vt[0]  = '{mk(0, 0, 0, 0, 5, 1, 0), 0, ex(0, 0, 0, 0, 0, 0, 0, 0)};
    vt[1]  = '{mk(5, 1, 1, 1, 6, 1, 0), 0, ex(0, 0, 0, 0, 0, 0, 0, 0)};
    vt[2]  = '{nop,                     0, ex(2, 0, 0, 0, 0, 0, 0, 0)};
    vt[3]  = '{mk(2, 0, 1, 0, 7, 1, 1), 0, ex(0, 0, 0, 0, 0, 0, 0, 0)};
    vt[4]  = '{rdr7,                    0, ex(0, 0, 1, 1, 0, 1, 0, 0)};
    vt[5]  = '{rdr7,                    0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[6]  = '{nop,                     0, ex(1, 1, 0, 0, 0, 0, 1, 0)};
    vt[7]  = '{mk(0, 0, 0, 0, 0, 1, 0), 0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[8]  = '{mk(3, 0, 1, 0, 0, 1, 1), 0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[9]  = '{mk(0, 0, 1, 1, 10, 1, 0), 0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[10] = '{nop,                     0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[11] = '{mk(0, 0, 0, 0, 5, 1, 0), 0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[12] = '{mk(0, 0, 0, 0, 9, 1, 0), 0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[13] = '{cons5,                   0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[14] = '{nop,                     0, ex(0, 1, 0, 0, 0, 0, 1, 0)};
    vt[15] = '{mk(0, 0, 0, 0, 5, 1, 0), 0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[16] = '{mk(0, 0, 0, 0, 5, 1, 0), 0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[17] = '{cons5,                   0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[18] = '{nop,                     0, ex(0, 2, 0, 0, 0, 0, 1, 0)};
    vt[19] = '{mk(2, 0, 1, 0, 7, 1, 1), 0, ex(0, 0, 0, 0, 0, 0, 1, 0)};
    vt[20] = '{rdr7,                    1, ex(0, 0, 0, 0, 1, 1, 1, 0)};
    vt[21] = '{nop,                     0, ex(0, 0, 0, 0, 0, 0, 1, 1)};

    do_reset();
    @(negedge clk);
    check("reset_state", obs(), ex(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    for (int k = 0; k < 22; k++) begin
      drive(vt[k].i, vt[k].pc);
      @(negedge clk);
      check($sformatf("vec%0d", k), obs(), vt[k].exp);
      @(posedge clk); #1;
    end

    // Reset arriving during a load-use stall must leave nothing behind.
    do_reset();
    drive(mk(2, 0, 1, 0, 7, 1, 1), 1'b0);
    @(posedge clk); #1;
    drive(rdr7, 1'b0);
    @(negedge clk);
    check("stall_before_rst", obs(), ex(0, 0, 1, 1, 0, 1, 0, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("stall_aborted_by_rst", obs(), ex(0, 0, 0, 0, 0, 0, 0, 0));

    // Counter saturation: a branch every cycle flushes every cycle.
    do_reset();
    drive(nop, 1'b1);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("flush_cnt_saturated", obs(), ex(0, 0, 0, 0, 1, 1, 0, 65535));
    drive(nop, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("after_sat_rst", obs(), ex(0, 0, 0, 0, 0, 0, 0, 0));

    // Randomized run against the reference model.
    do_reset();
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0; m_sc = 0; m_fc = 0;
    for (int n = 0; n < 3000; n++) begin
      instr_t x;
      logic   pc, r;
      x  = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      pc = $urandom_range(0, 9) == 0;
      r  = $urandom_range(0, 199) == 0;
      drive(x, pc);
      rst = r;
      @(negedge clk);
      check($sformatf("rand%0d", n), obs(), model_out(x, pc));
      model_step(x, pc, r);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
